// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction-fetch stage of a simple multi-cycle CPU. It holds the PC,
//   requests each instruction word from instruction memory, presents the
//   registered word to the control unit and picks the next PC when the
//   instruction retires.
//
//   FSM: BOOT -> REQ -> EXEC -> REQ -> ...
//     BOOT : one idle cycle after reset, no memory request.
//     REQ  : IMEM_READ and BUSYWAIT high, IMEM_ADDR held stable. The word is
//            captured on the first edge that sees IMEM_BUSYWAIT low.
//     EXEC : INSTRUCTION valid. STALL holds everything. With STALL low the
//            instruction retires and PC moves on.
//
// Handshake: IMEM_READ is a level request that stays high with a constant
// IMEM_ADDR until an edge sees IMEM_BUSYWAIT low; IMEM_READDATA is taken on
// that edge and the request drops in the following cycle.
//
// Ports
//   CLK            in   clock, rising edge
//   RESET          in   synchronous active-high reset
//   JUMP           in   unconditional jump flag
//   BRANCH[1:0]    in   01 = beq, 10 = bne, 00/11 = none
//   ZERO           in   ALU zero flag
//   STALL          in   data-memory busywait, holds the current instruction
//   IMEM_READDATA  in   instruction word from memory (I bits)
//   IMEM_BUSYWAIT  in   instruction-memory read still in progress
//   IMEM_READ      out  instruction-memory read request
//   IMEM_ADDR      out  word address PC[AW+1:2]
//   PC             out  byte address of INSTRUCTION
//   INSTRUCTION    out  registered instruction word
//   INSTR_VALID    out  INSTRUCTION holds a fetched, unretired instruction
//   BUSYWAIT       out  fetch outstanding, freezes the datapath
//   INSTR_COUNT    out  retired instruction count (wraps)
//   DBG_STATE      out  FSM state (0 BOOT, 1 REQ, 2 EXEC)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int I  = 32,
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          JUMP,
    input  logic [1:0]    BRANCH,
    input  logic          ZERO,
    input  logic          STALL,
    input  logic [I-1:0]  IMEM_READDATA,
    input  logic          IMEM_BUSYWAIT,
    output logic          IMEM_READ,
    output logic [AW-1:0] IMEM_ADDR,
    output logic [I-1:0]  PC,
    output logic [I-1:0]  INSTRUCTION,
    output logic          INSTR_VALID,
    output logic          BUSYWAIT,
    output logic [31:0]   INSTR_COUNT,
    output logic [1:0]    DBG_STATE
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_EXEC = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next_state;
    logic [I-1:0] r_pc;
    logic [I-1:0] r_instr;
    logic         r_valid;
    logic [31:0]  r_count;

    logic [I-1:0] w_pc_plus4;
    logic [I-1:0] w_offset;
    logic [I-1:0] w_target;
    logic         w_take;
    logic [I-1:0] w_next_pc;
    logic         w_load;
    logic         w_retire;

    // Offset field INSTRUCTION[23:16], sign-extended and scaled to bytes.
    // All PC arithmetic is plain I-bit addition, so it wraps modulo 2^I.
    assign w_pc_plus4 = r_pc + {{(I-3){1'b0}}, 3'b100};
    assign w_offset   = {{(I-10){r_instr[23]}}, r_instr[23:16], 2'b00};
    assign w_target   = w_pc_plus4 + w_offset;

    // Jump first, then beq taken, then bne taken; BRANCH=11 is "none".
    assign w_take = JUMP
                 || ((BRANCH == 2'b01) && ZERO)
                 || ((BRANCH == 2'b10) && !ZERO);
    assign w_next_pc = w_take ? w_target : w_pc_plus4;

    assign w_load   = (r_state == S_REQ)  && !IMEM_BUSYWAIT;
    assign w_retire = (r_state == S_EXEC) && !STALL;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_BOOT;
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_instr <= IMEM_READDATA;
                r_valid <= 1'b1;
            end
            if (w_retire) begin
                r_pc    <= w_next_pc;
                r_valid <= 1'b0;
                r_count <= r_count + 32'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        IMEM_READ    = 1'b0;
        BUSYWAIT     = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_next_state = S_REQ;
            end
            S_REQ: begin
                IMEM_READ = 1'b1;
                BUSYWAIT  = 1'b1;
                if (!IMEM_BUSYWAIT) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!STALL) begin
                    w_next_state = S_REQ;
                end
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    assign IMEM_ADDR   = r_pc[AW+1:2];
    assign PC          = r_pc;
    assign INSTRUCTION = r_instr;
    assign INSTR_VALID = r_valid;
    assign INSTR_COUNT = r_count;
    assign DBG_STATE   = r_state;

endmodule
